// File: rtl/serial_paralelo_pkg.sv
// serial_paralelo_pkg: shared link symbols and receiver FSM encodings.
package serial_paralelo_pkg;
    localparam logic [7:0] COM_SYM_DEF = 8'hBC;
    localparam logic [1:0] SEARCH = 2'd0;
    localparam logic [1:0] ALIGN  = 2'd1;
    localparam logic [1:0] ACTIVE = 2'd2;
endpackage

// File: rtl/com_detect.sv
// com_detect: combinational match of a candidate byte against the COM symbol.
module com_detect #(
    parameter logic [7:0] SYM = 8'hBC
) (
    input  logic [7:0] w_i,
    output logic       is_com_o
);
    assign is_com_o = (w_i == SYM);
endmodule

// File: rtl/serial_paralelo.sv
// serial_paralelo: deserialises the MSB-first bit stream, aligning on COM symbols
// and emitting one byte per 8 bit-times once the link is active.
module serial_paralelo
    import serial_paralelo_pkg::*;
#(
    parameter logic [7:0] COM_SYM   = COM_SYM_DEF,
    parameter logic [3:0] COM_COUNT = 4'd4
) (
    input  logic       clk32_f,
    input  logic       reset_L,
    input  logic       data_in,
    output logic [7:0] data_out,
    output logic       valid_out,
    output logic       byte_strobe,
    output logic       active,
    output logic [3:0] com_cnt
);
    logic [7:0] sr_q, sr_d, data_q, data_d, w;
    logic [2:0] bit_cnt_q, bit_cnt_d;
    logic [3:0] com_cnt_q, com_cnt_d;
    logic [1:0] state_q, state_d;
    logic       valid_q, valid_d, strobe_q, strobe_d, active_q, active_d;
    logic       is_com, boundary;

    assign w        = {sr_q[6:0], data_in};
    assign boundary = (bit_cnt_q == 3'd7);

    com_detect #(.SYM(COM_SYM)) u_com_detect (.w_i(w), .is_com_o(is_com));

    always_comb begin
        sr_d      = w;
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q + 3'd1;
        com_cnt_d = com_cnt_q;
        data_d    = data_q;
        valid_d   = valid_q;
        strobe_d  = 1'b0;
        active_d  = active_q;
        if (state_q == SEARCH) begin
            bit_cnt_d = 3'd0;
            if (is_com) begin
                com_cnt_d = 4'd1;
                state_d   = ALIGN;
            end
        end else if (state_q == ALIGN) begin
            if (boundary && is_com && (com_cnt_q + 4'd1 == COM_COUNT)) begin
                com_cnt_d = COM_COUNT;
                active_d  = 1'b1;
                state_d   = ACTIVE;
            end else if (boundary && is_com) begin
                com_cnt_d = com_cnt_q + 4'd1;
            end else if (boundary) begin
                com_cnt_d = 4'd0;
                state_d   = SEARCH;
            end
        end else if (state_q == ACTIVE) begin
            data_d   = boundary ? w : data_q;
            valid_d  = boundary ? !is_com : valid_q;
            strobe_d = boundary;
        end else begin
            bit_cnt_d = 3'd0;
            state_d   = SEARCH;
        end
    end

    always_ff @(posedge clk32_f or negedge reset_L) begin
        if (!reset_L) begin
            sr_q      <= '0;
            state_q   <= SEARCH;
            bit_cnt_q <= '0;
            com_cnt_q <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            strobe_q  <= 1'b0;
            active_q  <= 1'b0;
        end else begin
            sr_q      <= sr_d;
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            com_cnt_q <= com_cnt_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            strobe_q  <= strobe_d;
            active_q  <= active_d;
        end
    end

    assign data_out    = data_q;
    assign valid_out   = valid_q;
    assign byte_strobe = strobe_q;
    assign active      = active_q;
    assign com_cnt     = com_cnt_q;
endmodule

// File: tb/tb_serial_paralelo.sv
// tb_serial_paralelo: directed checks of alignment, data emission and reset behaviour.
module tb_serial_paralelo;
    logic       clk32_f = 1'b0;
    logic       reset_L = 1'b0;
    logic       data_in = 1'b0;
    logic [7:0] data_out;
    logic       valid_out, byte_strobe, active;
    logic [3:0] com_cnt;
    int         total = 0;
    int         bad = 0;
    int         nstrobe = 0;

    serial_paralelo dut (
        .clk32_f(clk32_f), .reset_L(reset_L), .data_in(data_in),
        .data_out(data_out), .valid_out(valid_out), .byte_strobe(byte_strobe),
        .active(active), .com_cnt(com_cnt)
    );

    always #5 clk32_f = ~clk32_f;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send_bit(input logic b);
        data_in = b;
        @(posedge clk32_f);
        #1;
        if (byte_strobe) nstrobe++;
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
    endtask

    task automatic do_reset();
        #2 reset_L = 1'b0;
        @(posedge clk32_f);
        #1 reset_L = 1'b1;
        nstrobe = 0;
    endtask

    task automatic check_out(input string tag, input logic [7:0] d, input logic v);
        check({tag, " strobe"}, {31'd0, byte_strobe}, 32'd1);
        check({tag, " data"}, {24'd0, data_out}, {24'd0, d});
        check({tag, " valid"}, {31'd0, valid_out}, {31'd0, v});
    endtask

    initial begin
        logic [7:0] fc [5];
        fc = '{8'h5E, 8'h0B, 8'hC0, 8'h17, 8'h80};
        for (int i = 0; i < 6; i++) begin
            data_in = 1'($urandom_range(0, 1));
            @(posedge clk32_f);
            #1;
        end
        check("rst outputs", {data_out, valid_out, byte_strobe, active, com_cnt}, 32'd0);
        reset_L = 1'b1;
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("junk com_cnt", {28'd0, com_cnt}, 32'd0);
        for (int k = 1; k <= 4; k++) begin
            send_byte(8'hBC);
            check($sformatf("align com_cnt %0d", k), {28'd0, com_cnt}, k);
            check($sformatf("align active %0d", k), {31'd0, active}, (k == 4) ? 32'd1 : 32'd0);
        end
        check("align no strobes", nstrobe, 32'd0);
        send_byte(8'h5A); check_out("t2 5A", 8'h5A, 1'b1);
        send_byte(8'hBC); check_out("t2 BC", 8'hBC, 1'b0);
        send_byte(8'hFF); check_out("t2 FF", 8'hFF, 1'b1);
        check("t2 strobe count", nstrobe, 32'd3);

        do_reset();
        send_byte(8'hBC); check("brk cnt1", {28'd0, com_cnt}, 32'd1);
        send_byte(8'hBC); check("brk cnt2", {28'd0, com_cnt}, 32'd2);
        send_byte(8'h00); check("brk cnt0", {28'd0, com_cnt}, 32'd0);
        for (int k = 1; k <= 4; k++) send_byte(8'hBC);
        check("brk reacq active", {31'd0, active}, 32'd1);
        check("brk reacq cnt", {28'd0, com_cnt}, 32'd4);
        check("brk no early strobe", nstrobe, 32'd0);
        send_byte(8'h33); check_out("brk 33", 8'h33, 1'b1);

        nstrobe = 0;
        for (int i = 0; i < 5; i++) begin
            send_byte(fc[i]);
            check_out($sformatf("falsecom %0d", i), fc[i], 1'b1);
        end
        check("falsecom strobes", nstrobe, 32'd5);

        for (int i = 0; i < 4; i++) begin
            send_byte(8'hBC);
            check($sformatf("loop idle valid %0d", i), {31'd0, valid_out}, 32'd0);
        end
        for (int i = 1; i <= 16; i++) begin
            send_byte(8'(i));
            check($sformatf("loop data %0d", i), {23'd0, valid_out, data_out}, {23'd0, 1'b1, 8'(i)});
        end

        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        #2 reset_L = 1'b0;
        #1;
        check("async rst clear", {data_out, valid_out, byte_strobe, active, com_cnt}, 32'd0);
        @(posedge clk32_f);
        #1 reset_L = 1'b1;
        send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1);
        check("mid rst cnt0", {28'd0, com_cnt}, 32'd0);
        for (int k = 1; k <= 3; k++) send_byte(8'hBC);
        check("mid rst 3 BC cnt", {28'd0, com_cnt}, 32'd3);
        check("mid rst 3 BC inactive", {31'd0, active}, 32'd0);
        send_byte(8'hBC);
        check("mid rst 4 BC active", {31'd0, active}, 32'd1);
        send_byte(8'hC3); check_out("mid rst C3", 8'hC3, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
